gerenciador_caminho_anterior: RTL

Parametrised predecessor ("anterior") memory for the shortest-path engine: stores one predecessor node id per node together with a per-entry valid flag. Adds a hardware bulk-clear sweep and, optionally, a path traceback engine that walks predecessors from a destination back to a source and streams the node sequence out over a ready/valid interface. It replaces the plain dual-port predecessor wrapper between the relaxation datapath and the path output logic.

---
 rtl/gerenciador_caminho_anterior.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gerenciador_caminho_anterior.sv
// gerenciador_caminho_anterior: predecessor RAM {valid, pred} with hardware bulk clear.
// Optional path traceback engine enabled by defining ANTERIOR_TRACE_EN.
module gerenciador_caminho_anterior #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en_i,
  input  logic [ADDR_WIDTH-1:0] write_addr_i,
  input  logic [ADDR_WIDTH-1:0] data_i,
  input  logic                  read_en_i,
  input  logic [ADDR_WIDTH-1:0] read_addr_i,
  output logic [ADDR_WIDTH-1:0] data_o,
  output logic                  anterior_valido_o,
  output logic                  read_valid_o,
  input  logic                  clear_i,
  output logic                  busy_o,
  input  logic                  trace_start_i,
  input  logic [ADDR_WIDTH-1:0] trace_src_i,
  input  logic [ADDR_WIDTH-1:0] trace_dest_i,
  output logic [ADDR_WIDTH-1:0] path_node_o,
  output logic                  path_valid_o,
  input  logic                  path_ready_i,
  output logic                  path_last_o,
  output logic                  trace_err_o
);
  localparam int RAM_WIDTH = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
`ifdef ANTERIOR_TRACE_EN
  typedef enum logic [2:0] {IDLE, CLEAR, T_READ, T_WAIT, T_EMIT} state_t;
`else
  typedef enum logic [0:0] {IDLE, CLEAR} state_t;
`endif
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic rvalid_q, rvalid_d;
  logic [RAM_WIDTH-1:0] mem [DEPTH];
  logic [RAM_WIDTH-1:0] rd_q, wdata;
  logic we, re;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  // Nonblocking read and write in one block gives read-first on collisions
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_q <= mem[raddr];
  end
  assign busy_o = state_q != IDLE;
  assign read_valid_o = rvalid_q;
  assign data_o = rvalid_q ? rd_q[ADDR_WIDTH-1:0] : '0;
  assign anterior_valido_o = rvalid_q & rd_q[ADDR_WIDTH];
`ifdef ANTERIOR_TRACE_EN
  logic [ADDR_WIDTH-1:0] src_q, src_d, cur_q, cur_d, step_q, step_d;
  logic [RAM_WIDTH-1:0] pred_q, pred_d;
  logic emit, err, last;
  assign emit = state_q == T_EMIT;
  // Step limit catches predecessor loops that never reach the source
  assign err = emit && cur_q != src_q && (!pred_q[ADDR_WIDTH] || step_q == LAST_ADDR);
  assign last = emit && (cur_q == src_q || err);
  assign path_valid_o = emit;
  assign path_node_o = emit ? cur_q : '0;
  assign path_last_o = last;
  assign trace_err_o = err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      cur_q <= '0;
      step_q <= '0;
      pred_q <= '0;
    end else begin
      src_q <= src_d;
      cur_q <= cur_d;
      step_q <= step_d;
      pred_q <= pred_d;
    end
  end
`else
  logic unused_trace;
  assign unused_trace = ^{trace_start_i, trace_src_i, trace_dest_i, path_ready_i};
  assign path_valid_o = 1'b0;
  assign path_node_o = '0;
  assign path_last_o = 1'b0;
  assign trace_err_o = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rvalid_d = 1'b0;
    we = 1'b0;
    waddr = write_addr_i;
    wdata = {1'b1, data_i};
    re = 1'b0;
    raddr = read_addr_i;
`ifdef ANTERIOR_TRACE_EN
    src_d = src_q;
    cur_d = cur_q;
    step_d = step_q;
    pred_d = pred_q;
`endif
    case (state_q)
      IDLE: begin
        we = write_en_i;
        re = read_en_i;
        rvalid_d = read_en_i;
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d = '0;
        end
`ifdef ANTERIOR_TRACE_EN
        else if (trace_start_i) begin
          state_d = T_READ;
          src_d = trace_src_i;
          cur_d = trace_dest_i;
          step_d = '0;
        end
`endif
      end
      CLEAR: begin
        we = 1'b1;
        waddr = cnt_q;
        wdata = '0;
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == LAST_ADDR ? IDLE : CLEAR;
      end
`ifdef ANTERIOR_TRACE_EN
      T_READ: begin
        re = 1'b1;
        raddr = cur_q;
        state_d = T_WAIT;
      end
      T_WAIT: begin
        pred_d = rd_q;
        state_d = T_EMIT;
      end
      T_EMIT: begin
        if (path_ready_i) begin
          state_d = last ? IDLE : T_READ;
          cur_d = last ? cur_q : pred_q[ADDR_WIDTH-1:0];
          step_d = last ? step_q : step_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end
endmodule
